lza_norm_pipe: RTL and testbench

//  Pipelined, parametrised successor to the FP-adder LZA/normaliser. Takes the adder operands
//  and raw sum, anticipates leading zeros, left-normalises, then applies the 1-bit LZA correction.

---
 rtl/lza_norm_pipe.sv | 134 +++++++++++++
 tb/tb_lza_norm_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lza_norm_pipe.sv
// Three-stage pipelined leading-zero anticipator and normaliser, placed between significand adder and rounder.
// Define LZA_NORM_STICKY_EN to add the out_sticky port (OR of the bits dropped below out_mant).
module lza_norm_pipe #(
    parameter int MAN_W = 24,
    parameter int IN_W  = MAN_W + 3,
    parameter int SHW   = $clog2(IN_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_a,
    input  logic [IN_W-1:0]   in_b,
    input  logic [IN_W-1:0]   in_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MAN_W-1:0]  out_mant,
    output logic [SHW-1:0]    out_shl,
    output logic              out_zero
`ifdef LZA_NORM_STICKY_EN
    ,
    output logic              out_sticky
`endif
);

`ifdef LZA_NORM_STICKY_EN
    localparam int SH2_W = IN_W;
`else
    localparam int SH2_W = MAN_W + 1;
`endif

    logic              v1, v2;
    logic              ld1, ld2, ld3;
    logic [IN_W-1:0]   t_hi, g, z, g_lo, z_lo, e;
    logic [IN_W-1:0]   e1, sum1;
    logic              zero1;
    logic [SHW-1:0]    lz;
    logic [SH2_W-1:0]  sh2;
    logic [SHW-1:0]    l2;
    logic              zero2;
    logic              corr;
    logic [MAN_W-1:0]  mant_n;
    logic [SHW-1:0]    shl_n;

    assign ld3      = !out_valid || out_ready;
    assign ld2      = !v2 || ld3;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;

    // Neighbour vectors carry the T[IN_W]=0 and G[-1]=Z[-1]=0 boundary terms.
    assign t_hi = {1'b0, in_a[IN_W-1:1] ^ in_b[IN_W-1:1]};
    assign g    = in_a & in_b;
    assign z    = ~in_a & ~in_b;
    assign g_lo = {g[IN_W-2:0], 1'b0};
    assign z_lo = {z[IN_W-2:0], 1'b0};
    assign e    = (t_hi & ((g & ~z_lo) | (z & ~g_lo)))
                | (~t_hi & ((z & ~z_lo) | (g & ~g_lo)));

    always_comb begin
        logic found;
        lz    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (!found && e1[IN_W-1-i]) begin
                lz    = SHW'(i);
                found = 1'b1;
            end
        end
    end

    assign corr   = !sh2[SH2_W-1] && !zero2;
    assign mant_n = corr ? sh2[SH2_W-2 -: MAN_W] : sh2[SH2_W-1 -: MAN_W];
    assign shl_n  = corr ? l2 + SHW'(1) : l2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (ld1) v1        <= in_valid;
            if (ld2) v2        <= v1;
            if (ld3) out_valid <= v2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1    <= '0;
            sum1  <= '0;
            zero1 <= 1'b0;
            sh2   <= '0;
            l2    <= '0;
            zero2 <= 1'b0;
        end else begin
            if (ld1 && in_valid) begin
                e1    <= e;
                sum1  <= in_sum;
                zero1 <= (in_sum == '0);
            end
            if (ld2 && v1) begin
                // Only the bits that can reach out_mant (or sticky) are kept past the coarse shift.
                sh2   <= SH2_W'((sum1 << lz) >> (IN_W - SH2_W));
                l2    <= lz;
                zero2 <= zero1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_mant   <= '0;
            out_shl    <= '0;
            out_zero   <= 1'b0;
`ifdef LZA_NORM_STICKY_EN
            out_sticky <= 1'b0;
`endif
        end else if (ld3 && v2) begin
            out_mant   <= zero2 ? '0 : mant_n;
            out_shl    <= zero2 ? '0 : shl_n;
            out_zero   <= zero2;
`ifdef LZA_NORM_STICKY_EN
            out_sticky <= zero2 ? 1'b0
                        : corr ? |sh2[IN_W-MAN_W-2:0] : |sh2[IN_W-MAN_W-1:0];
`endif
        end
    end

endmodule

// File: tb/tb_lza_norm_pipe.sv
// Self-checking bench for lza_norm_pipe: exact-LZC reference model, scoreboard and directed scenarios.
// Compile with LZA_NORM_STICKY_EN defined to also check out_sticky.
module tb_lza_norm_pipe;
    localparam int MAN_W = 24;
    localparam int IN_W  = 27;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready;
    logic [IN_W-1:0]  in_a, in_b, in_sum;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [MAN_W-1:0] out_mant;
    logic [SHW-1:0]   out_shl;
    logic             out_zero;
`ifdef LZA_NORM_STICKY_EN
    logic             out_sticky;
`endif

    lza_norm_pipe #(.MAN_W(MAN_W), .IN_W(IN_W), .SHW(SHW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_shl(out_shl), .out_zero(out_zero)
`ifdef LZA_NORM_STICKY_EN
        , .out_sticky(out_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MAN_W-1:0] mant;
        logic [SHW-1:0]   shl;
        logic             zero;
        logic             sticky;
        logic             lit;
        logic [MAN_W-1:0] lmant;
        logic [SHW-1:0]   lshl;
        logic             lzero;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic             lit_en = 1'b0;
    logic [MAN_W-1:0] lit_mant = '0;
    logic [SHW-1:0]   lit_shl = '0;
    logic             lit_zero = 1'b0;
    int               ready_mode = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact leading-zero count of the sum, then a single normalising shift.
    function automatic exp_t model(input logic [IN_W-1:0] s);
        exp_t r;
        int unsigned lzc;
        logic [IN_W-1:0] n;
        r = '{default: '0};
        if (s == '0) begin
            r.zero = 1'b1;
            return r;
        end
        lzc = 0;
        while (s[IN_W-1-lzc] == 1'b0) lzc++;
        n = s << lzc;
        r.mant   = n[IN_W-1 -: MAN_W];
        r.shl    = SHW'(lzc);
        r.sticky = |n[IN_W-MAN_W-1:0];
        return r;
    endfunction

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    logic             hold = 1'b0;
    logic [MAN_W-1:0] h_mant;
    logic [SHW-1:0]   h_shl;
    logic             h_zero;
    exp_t             ex, nw;

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_mant", {8'd0, out_mant}, {8'd0, h_mant});
                check("stall_shl", {27'd0, out_shl}, {27'd0, h_shl});
                check("stall_zero", {31'd0, out_zero}, {31'd0, h_zero});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_beat", 32'd1, 32'd0);
                end else begin
                    ex = q.pop_front();
                    check("mant", {8'd0, out_mant}, {8'd0, ex.mant});
                    check("shl", {27'd0, out_shl}, {27'd0, ex.shl});
                    check("zero", {31'd0, out_zero}, {31'd0, ex.zero});
`ifdef LZA_NORM_STICKY_EN
                    check("sticky", {31'd0, out_sticky}, {31'd0, ex.sticky});
`endif
                    if (ex.lit) begin
                        check("lit_mant", {8'd0, out_mant}, {8'd0, ex.lmant});
                        check("lit_shl", {27'd0, out_shl}, {27'd0, ex.lshl});
                        check("lit_zero", {31'd0, out_zero}, {31'd0, ex.lzero});
`ifdef LZA_NORM_STICKY_EN
                        check("lit_sticky", {31'd0, out_sticky}, 32'd0);
`endif
                    end
                end
            end
            hold   = out_valid && !out_ready;
            h_mant = out_mant;
            h_shl  = out_shl;
            h_zero = out_zero;
            if (in_valid && in_ready) begin
                nw       = model(in_sum);
                nw.lit   = lit_en;
                nw.lmant = lit_mant;
                nw.lshl  = lit_shl;
                nw.lzero = lit_zero;
                q.push_back(nw);
            end
        end
    end

    task automatic send(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b, input logic [IN_W-1:0] s,
                        input logic le, input logic [MAN_W-1:0] lm, input logic [SHW-1:0] ls,
                        input logic lz);
        logic r;
        int unsigned n;
        in_a = a; in_b = b; in_sum = s;
        lit_en = le; lit_mant = lm; lit_shl = ls; lit_zero = lz;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 200);
        if (!r) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        lit_en   = 1'b0;
    endtask

    task automatic drain(input string nm);
        int unsigned n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(nm, q.size(), 32'd0);
    endtask

    task automatic latency3(input string nm);
        @(negedge clk); check({nm, "_c1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk); check({nm, "_c2"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk); check({nm, "_c3"}, {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0] x, msk;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_mant", {8'd0, out_mant}, 32'd0);
        check("rst_out_shl", {27'd0, out_shl}, 32'd0);
        check("rst_out_zero", {31'd0, out_zero}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(27'h2000000, 27'h2000000, 27'h4000000, 1'b1, 24'h800000, 5'd0, 1'b0); idle();
        latency3("lat_msb");
        send(27'h0000800, 27'h0, 27'h0000800, 1'b1, 24'h800000, 5'd15, 1'b0); idle();
        send(27'h0, 27'h0, 27'h0, 1'b1, 24'h0, 5'd0, 1'b1); idle();
        // Subtract with complemented operand: anticipator lands one short, correction yields 26.
        send(27'h2000000, 27'h6000001, 27'h0000001, 1'b1, 24'h800000, 5'd26, 1'b0); idle();
        drain("drain_directed");

        ready_mode = 2;
        for (int k = 0; k < 26; k++) begin
            msk = (27'd1 << k) - 27'd1;
            x   = (27'd1 << k) | (IN_W'($urandom) & msk);
            send(x, 27'h0, x, 1'b0, '0, '0, 1'b0);
            send(x, x, x << 1, 1'b0, '0, '0, 1'b0);
        end
        idle();
        ready_mode = 1;
        drain("drain_sweep");

        ready_mode = 0;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(27'h0000100 << k, 27'h0, 27'h0000100 << k, 1'b0, '0, '0, 1'b0);
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #3;
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                check("stall_depth", q.size(), 32'd3);
                ready_mode = 1;
            end
        join
        drain("drain_stall");

        ready_mode = 0;
        for (int k = 0; k < 3; k++)
            send(27'h0000040 << k, 27'h0, 27'h0000040 << k, 1'b0, '0, '0, 1'b0);
        idle();
        @(negedge clk);
        check("pre_flush_full", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b1;
        in_valid = 1'b1; in_a = 27'h123; in_b = '0; in_sum = 27'h123;
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        ready_mode = 1;
        repeat (6) begin
            @(negedge clk);
            check("flush_no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        send(27'h0000777, 27'h0, 27'h0000777, 1'b0, '0, '0, 1'b0); idle();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send(27'h0008000, 27'h0, 27'h0008000, 1'b1, 24'h800000, 5'd11, 1'b0); idle();
        latency3("lat_after_rst");
        drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
